md5_dispatch_ctrl: RTL and testbench
====================================

// Module: md5_dispatch_ctrl
// PURPOSE
//  Round-robin scheduler sharing NUM_CORES pancham MD5 cores among one candidate stream.
//  Accepts 128-bit candidate blocks (valid/ready), issues each to a free core, tags it with
//  its 48-bit candidate index, and compares every digest against target_hash.
//  Sits between the candidate generator and the core array; drives led/found in the top level.
// PARAMETERS
//  NUM_CORES  4   number of attached MD5 cores (1..8)
//  IDX_W      48  width of candidate index tag
// PORTS
//  clk             in   1             clock
//  reset           in   1             async active-high reset
//  start           in   1             pulse: clear results, IDLE->RUN
//  abort           in   1             level: stop dispatch, go to DRAIN
//  target_hash     in   128           digest searched for; sampled on start
//  cand_valid      in   1             candidate present
//  cand_ready      out  1             candidate accepted this cycle when valid&ready
//  cand_msg        in   128           candidate block, bit 0 = first message bit
//  cand_width      in   8             message length in bits (to core msg_in_width)
//  cand_idx        in   IDX_W         candidate index tag
//  cand_last       in   1             qualifies final candidate of stream
//  core_msg        out  128*NUM_CORES per-core message, slice k = core k
//  core_width      out  8*NUM_CORES   per-core width
//  core_valid      out  NUM_CORES     one-cycle issue pulse per core
//  core_ready      in   NUM_CORES     core idle/able to accept
//  core_out        in   128*NUM_CORES per-core digest
//  core_out_valid  in   NUM_CORES     digest valid pulse per core
//  found           out  1             sticky: match seen
//  found_idx       out  IDX_W         tag of matching candidate
//  done            out  1             sticky: search finished (found, exhausted or aborted)
//  busy            out  1             state is RUN or DRAIN
//  hash_count      out  32            completed-digest count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr_ptr=0, occ[]=0, tags 0, core_msg/core_width 0.
//  States: IDLE -start-> RUN; RUN -(match | abort | last accepted)-> DRAIN;
//   DRAIN -(occ==0)-> DONE; DONE -start-> RUN. start ignored in RUN/DRAIN.
//  Dispatch (RUN only): cand_ready = !occ[rr_ptr] & core_ready[rr_ptr] & !stop_cond, combinational.
//   On accept: core_valid[rr_ptr]=1 next cycle for exactly 1 cycle, core_msg/width slice
//   registered and held until next issue to that core, tag[rr_ptr]<=cand_idx, occ set,
//   rr_ptr<=rr_ptr+1 wrapping NUM_CORES-1->0. Max one issue per cycle; latency accept->core_valid = 1.
//  rr_ptr does not skip: if pointed core busy, stream stalls (keeps issue order = tag order per slot).
//  Completion: core_out_valid[k] clears occ[k] same edge; only counted if occ[k]=1 (spurious ignored).
//   Compare core_out slice == target_hash latched at start. Match: found<=1, found_idx<=tag[k].
//  Simultaneous matches: lowest k wins. Match while found already 1: found_idx unchanged.
//  Completion and new issue to same core same cycle: occ ends set (issue wins).
//  After match or abort, cand_ready=0 immediately (same cycle as the match edge onward);
//   in-flight digests still retired in DRAIN, not compared once found=1.
//  done<=1 on entering DONE; start clears found, found_idx, done, hash_count, rr_ptr.
//  Async reset mid-search: everything returns to reset values; cores are not reset by this block.
// CONFIGURATION
//  MD5_DISPATCH_COUNT_EN defined: hash_count increments (saturating at 2^32-1) on every
//   retired digest, including those during DRAIN; multiple same-cycle retirements add popcount.
//  Not defined: hash_count tied to 32'd0, counter logic absent.
// TESTING
//  T1 start, 3 candidates idx 0..2, NUM_CORES=4, cores ready -> core_valid 0001,0010,0100 in
//     consecutive cycles, tags 0,1,2; no match, cand_last on idx2 -> done=1, found=0.
//  T2 target=md5("a") (0cc175b9c0f1b6a831c399e269772661), idx 5 carries "a" width 8 ->
//     found=1, found_idx=5, cand_ready drops, done after all cores retire.
//  T3 core_ready[1]=0 with rr_ptr=1 -> cand_ready=0, no issue to core 2 until core 1 ready.
//  T4 cores 0 and 3 return matching digests same cycle, tags 8/11 -> found_idx=8.
//  T5 abort with 4 in flight -> no further accepts, busy until 4 core_out_valid seen, done=1;
//     with MD5_DISPATCH_COUNT_EN hash_count=4, without it 0.
//  T6 reset asserted mid-RUN with occ=1111 -> outputs 0 next cycle, IDLE; spurious core_out_valid ignored.

Source files
------------

// File: rtl/md5_dispatch_ctrl.sv
// Round-robin dispatcher sharing NUM_CORES MD5 cores across one candidate stream, with digest compare.
// Optional MD5_DISPATCH_COUNT_EN enables the saturating retired-digest counter on hash_count.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | accepting candidates and issuing them to cores in strict rotation
// DRAIN | no more issues; retiring in-flight digests
// DONE  | search finished; start begins a new search
module md5_dispatch_ctrl #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = 48
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [127:0]             target_hash,
    input  logic                     cand_valid,
    output logic                     cand_ready,
    input  logic [127:0]             cand_msg,
    input  logic [7:0]               cand_width,
    input  logic [IDX_W-1:0]         cand_idx,
    input  logic                     cand_last,
    output logic [128*NUM_CORES-1:0] core_msg,
    output logic [8*NUM_CORES-1:0]   core_width,
    output logic [NUM_CORES-1:0]     core_valid,
    input  logic [NUM_CORES-1:0]     core_ready,
    input  logic [128*NUM_CORES-1:0] core_out,
    input  logic [NUM_CORES-1:0]     core_out_valid,
    output logic                     found,
    output logic [IDX_W-1:0]         found_idx,
    output logic                     done,
    output logic                     busy,
    output logic [31:0]              hash_count
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr;
    logic [NUM_CORES-1:0] occ;
    logic [IDX_W-1:0]     tag_q [NUM_CORES];
    logic [127:0]         target_q;
    logic [NUM_CORES-1:0] retire;
    logic [NUM_CORES-1:0] match_vec;
    logic                 match_any;
    logic [IDX_W-1:0]     match_tag;
    logic                 start_ok;
    logic                 issue;
    logic                 stop_cond;

    // Only digests from occupied cores count; once found, later digests are retired uncompared.
    always_comb begin
        retire    = '0;
        match_vec = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            retire[k]    = core_out_valid[k] & occ[k];
            match_vec[k] = retire[k] & ~found & (core_out[k*128 +: 128] == target_q);
        end
    end

    // Descending scan so the lowest-numbered matching core overrides.
    always_comb begin
        match_any = 1'b0;
        match_tag = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (match_vec[k]) begin
                match_any = 1'b1;
                match_tag = tag_q[k];
            end
        end
    end

    assign start_ok  = start & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign stop_cond = abort | found | match_any;
    assign busy      = (state_q == S_RUN) | (state_q == S_DRAIN);

    always_comb begin
        state_d    = state_q;
        cand_ready = (state_q == S_RUN) & ~occ[rr_ptr] & core_ready[rr_ptr] & ~stop_cond;
        issue      = cand_valid & cand_ready;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_RUN;
            S_RUN:   if (match_any | abort | (issue & cand_last)) state_d = S_DRAIN;
            S_DRAIN: if (occ == '0) state_d = S_DONE;
            S_DONE:  if (start_ok) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_ptr     <= '0;
            occ        <= '0;
            target_q   <= '0;
            core_msg   <= '0;
            core_width <= '0;
            core_valid <= '0;
            found      <= 1'b0;
            found_idx  <= '0;
            done       <= 1'b0;
            for (int k = 0; k < NUM_CORES; k++) tag_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            core_valid <= '0;
            if (start_ok) begin
                target_q  <= target_hash;
                found     <= 1'b0;
                found_idx <= '0;
                done      <= 1'b0;
                rr_ptr    <= '0;
            end
            if (issue) begin
                core_valid[rr_ptr]              <= 1'b1;
                core_msg[rr_ptr*128 +: 128]     <= cand_msg;
                core_width[rr_ptr*8 +: 8]       <= cand_width;
                tag_q[rr_ptr]                   <= cand_idx;
                rr_ptr <= (rr_ptr == PTR_W'(NUM_CORES - 1)) ? '0 : rr_ptr + 1'b1;
            end
            // A same-cycle issue to a retiring core leaves it occupied.
            for (int k = 0; k < NUM_CORES; k++) begin
                if (issue && (rr_ptr == PTR_W'(k))) occ[k] <= 1'b1;
                else if (retire[k])                 occ[k] <= 1'b0;
            end
            if (match_any) begin
                found     <= 1'b1;
                found_idx <= match_tag;
            end
            if ((state_q == S_DRAIN) && (state_d == S_DONE)) done <= 1'b1;
        end
    end

`ifdef MD5_DISPATCH_COUNT_EN
    logic [3:0]  ret_cnt;
    logic [32:0] cnt_sum;

    always_comb begin
        ret_cnt = '0;
        for (int k = 0; k < NUM_CORES; k++) ret_cnt = ret_cnt + 4'(retire[k]);
        cnt_sum = {1'b0, hash_count} + 33'(ret_cnt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            hash_count <= '0;
        else if (start_ok)    hash_count <= '0;
        else if (cnt_sum[32]) hash_count <= '1;
        else                  hash_count <= cnt_sum[31:0];
    end
`else
    assign hash_count = 32'd0;
`endif

endmodule

// File: tb/tb_md5_dispatch_ctrl.sv
// Directed bench for md5_dispatch_ctrl: the cores are emulated by driving core_ready/core_out by hand.
module tb_md5_dispatch_ctrl;

    localparam int NC = 4;
    localparam int IW = 48;
`ifdef MD5_DISPATCH_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [127:0] MD5A = 128'h0cc175b9c0f1b6a831c399e269772661;
    localparam logic [127:0] TH4  = 128'hfeedface_0badf00d_12345678_9abcdef0;

    logic              clk = 1'b0;
    logic              reset;
    logic              start, abort;
    logic [127:0]      target_hash;
    logic              cand_valid, cand_ready;
    logic [127:0]      cand_msg;
    logic [7:0]        cand_width;
    logic [IW-1:0]     cand_idx;
    logic              cand_last;
    logic [128*NC-1:0] core_msg;
    logic [8*NC-1:0]   core_width;
    logic [NC-1:0]     core_valid, core_ready;
    logic [128*NC-1:0] core_out;
    logic [NC-1:0]     core_out_valid;
    logic              found, done, busy;
    logic [IW-1:0]     found_idx;
    logic [31:0]       hash_count;

    int checks = 0;
    int errors = 0;

    md5_dispatch_ctrl #(.NUM_CORES(NC), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .target_hash(target_hash),
        .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_msg(cand_msg),
        .cand_width(cand_width), .cand_idx(cand_idx), .cand_last(cand_last),
        .core_msg(core_msg), .core_width(core_width), .core_valid(core_valid),
        .core_ready(core_ready), .core_out(core_out), .core_out_valid(core_out_valid),
        .found(found), .found_idx(found_idx), .done(done), .busy(busy), .hash_count(hash_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [127:0] t);
        start       = 1'b1;
        target_hash = t;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one candidate and returns on the negedge after it was accepted.
    task automatic push(input logic [IW-1:0] idx, input logic [127:0] msg,
                        input logic last, input logic [7:0] w);
        cand_valid = 1'b1;
        cand_idx   = idx;
        cand_msg   = msg;
        cand_last  = last;
        cand_width = w;
        #1;
        for (int i = 0; i < 20 && !cand_ready; i++) @(negedge clk);
        chk("push_ready", cand_ready, 1'b1);
        @(negedge clk);
        cand_valid = 1'b0;
        cand_last  = 1'b0;
    endtask

    task automatic retire(input logic [NC-1:0] mask, input logic [127:0] dig);
        core_out       = {NC{dig}};
        core_out_valid = mask;
        @(negedge clk);
        core_out_valid = '0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50 && !done; i++) @(negedge clk);
        chk("wait_done", done, 1'b1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; target_hash = '0;
        cand_valid = 1'b0; cand_msg = '0; cand_width = '0; cand_idx = '0; cand_last = 1'b0;
        core_ready = '1; core_out = '0; core_out_valid = '0;
        repeat (3) @(negedge clk);
        chk("rst_found", found, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", cand_ready, 1'b0);
        chk("rst_core_valid", core_valid, 4'b0000);
        chk("rst_core_msg", core_msg[127:0], 128'h0);
        chk("rst_count", hash_count, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // T1: three candidates issued in rotation, no match, last ends the stream
        do_start(128'h1111_2222_3333_4444_5555_6666_7777_8888);
        chk("t1_busy", busy, 1'b1);
        push(48'd0, 128'hA0, 1'b0, 8'd8);
        chk("t1_cv0", core_valid, 4'b0001);
        chk("t1_msg0", core_msg[127:0], 128'hA0);
        chk("t1_w0", core_width[7:0], 8'd8);
        push(48'd1, 128'hA1, 1'b0, 8'd16);
        chk("t1_cv1", core_valid, 4'b0010);
        chk("t1_w1", core_width[15:8], 8'd16);
        push(48'd2, 128'hA2, 1'b1, 8'd24);
        chk("t1_cv2", core_valid, 4'b0100);
        chk("t1_msg2", core_msg[383:256], 128'hA2);
        chk("t1_msg0_held", core_msg[127:0], 128'hA0);
        cand_valid = 1'b1;
        #1 chk("t1_ready_drain", cand_ready, 1'b0);
        cand_valid = 1'b0;
        chk("t1_busy_drain", busy, 1'b1);
        retire(4'b0111, 128'hdead);
        wait_done();
        chk("t1_found", found, 1'b0);
        chk("t1_busy_end", busy, 1'b0);
        chk("t1_count", hash_count, CNT_EN ? 32'd3 : 32'd0);

        // T2: idx 5 carries "a", its digest matches; pending candidate refused on the match cycle
        do_start(MD5A);
        chk("t2_done_clr", done, 1'b0);
        push(48'd3, 128'hB3, 1'b0, 8'd8);
        push(48'd4, 128'hB4, 1'b0, 8'd8);
        push(48'd5, 128'h61, 1'b0, 8'd8);
        chk("t2_msg_a", core_msg[383:256], 128'h61);
        cand_valid     = 1'b1;
        cand_idx       = 48'd6;
        core_out       = {NC{MD5A}};
        core_out_valid = 4'b0100;
        #1 chk("t2_ready_on_match", cand_ready, 1'b0);
        @(negedge clk);
        core_out_valid = '0;
        chk("t2_found", found, 1'b1);
        chk("t2_found_idx", found_idx, 48'd5);
        chk("t2_no_issue", core_valid, 4'b0000);
        chk("t2_ready_after", cand_ready, 1'b0);
        chk("t2_done_early", done, 1'b0);
        chk("t2_busy", busy, 1'b1);
        cand_valid = 1'b0;
        retire(4'b0011, 128'h0);
        wait_done();
        chk("t2_count", hash_count, CNT_EN ? 32'd3 : 32'd0);

        // T3: pointed core not ready stalls the stream; T5: abort with four in flight
        do_start(128'hbeef);
        push(48'd7, 128'hC7, 1'b0, 8'd8);
        core_ready = 4'b1101;
        cand_valid = 1'b1;
        cand_idx   = 48'd8;
        cand_msg   = 128'hC8;
        #1 chk("t3_stall_ready", cand_ready, 1'b0);
        repeat (3) @(negedge clk);
        chk("t3_stall_noissue", core_valid, 4'b0000);
        core_ready = 4'b1111;
        #1 chk("t3_resume_ready", cand_ready, 1'b1);
        @(negedge clk);
        chk("t3_issue_core1", core_valid, 4'b0010);
        cand_valid = 1'b0;
        push(48'd9, 128'hC9, 1'b0, 8'd8);
        push(48'd10, 128'hCA, 1'b0, 8'd8);
        chk("t5_cv3", core_valid, 4'b1000);
        cand_valid = 1'b1;
        cand_idx   = 48'd11;
        #1 chk("t5_full_ready", cand_ready, 1'b0);
        abort = 1'b1;
        retire(4'b0001, 128'h0);
        chk("t5_abort_ready", cand_ready, 1'b0);
        chk("t5_abort_noissue", core_valid, 4'b0000);
        chk("t5_busy1", busy, 1'b1);
        retire(4'b0010, 128'h0);
        retire(4'b0100, 128'h0);
        chk("t5_busy3", busy, 1'b1);
        retire(4'b1000, 128'h0);
        wait_done();
        chk("t5_busy_end", busy, 1'b0);
        chk("t5_found", found, 1'b0);
        chk("t5_count", hash_count, CNT_EN ? 32'd4 : 32'd0);
        abort = 1'b0;
        cand_valid = 1'b0;

        // T4: cores 0 and 3 match together; later match keeps the first index
        do_start(TH4);
        push(48'd8, 128'hD8, 1'b0, 8'd8);
        push(48'd9, 128'hD9, 1'b0, 8'd8);
        push(48'd10, 128'hDA, 1'b0, 8'd8);
        push(48'd11, 128'hDB, 1'b0, 8'd8);
        retire(4'b1001, TH4);
        chk("t4_found", found, 1'b1);
        chk("t4_lowest_wins", found_idx, 48'd8);
        retire(4'b0010, TH4);
        chk("t4_idx_sticky", found_idx, 48'd8);
        retire(4'b0100, 128'h0);
        wait_done();
        chk("t4_count", hash_count, CNT_EN ? 32'd4 : 32'd0);

        // T6: reset with all cores occupied, then spurious digests
        do_start(TH4);
        push(48'd20, 128'hE0, 1'b0, 8'd8);
        push(48'd21, 128'hE1, 1'b0, 8'd8);
        push(48'd22, 128'hE2, 1'b0, 8'd8);
        push(48'd23, 128'hE3, 1'b0, 8'd8);
        reset = 1'b1;
        #1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_core_valid", core_valid, 4'b0000);
        chk("t6_core_msg3", core_msg[511:384], 128'h0);
        chk("t6_core_width", core_width, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        retire(4'b1111, TH4);
        chk("t6_spurious_found", found, 1'b0);
        chk("t6_spurious_count", hash_count, 32'd0);
        chk("t6_spurious_busy", busy, 1'b0);
        chk("t6_done", done, 1'b0);
        do_start(TH4);
        chk("t6_restart_ready", cand_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
